adc_scan: RTL and testbench

ADC_SCAN -- requirements
Module: adc_scan

---
 rtl/adc_scan.sv | 189 ++++++++++++++++++
 tb/tb_adc_scan.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan.sv
// -----------------------------------------------------------------------------
// adc_scan
// Round-robin scanner for a 12-bit SPI ADC (MCP3204-style single-ended
// command). Each frame selects one channel, clocks 19 SCK periods, keeps the
// last 12 MISO samples (MSB first) and writes them to that channel's result
// register.
//
// Parameters
//   DIV  SCK half-period in clk cycles (2..255)
//   NCH  number of scanned channels (1..4)
//
// Ports
//   clk        system clock
//   reset      synchronous active-low reset
//   ena        continuous-scan enable
//   adc_cs     SPI chip select, active low
//   adc_si     SPI MOSI (command bits)
//   adc_clk    SPI SCK, idle low
//   adc_so     SPI MISO
//   a0..a3     latest result per channel
//   valid      one-clk strobe on a result update
//   valid_ch   channel index of the update flagged by valid
//   busy       high whenever the scanner is not idle
//
// Build option
//   ADC_FILT_EN  when defined, results pass through a first-order IIR
//                (a += (sample - a) >>> 2) instead of being stored directly.
// -----------------------------------------------------------------------------
module adc_scan #(
   parameter int DIV = 12,
   parameter int NCH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ena,
   output logic        adc_cs,
   output logic        adc_si,
   output logic        adc_clk,
   input  logic        adc_so,
   output logic [11:0] a0,
   output logic [11:0] a1,
   output logic [11:0] a2,
   output logic [11:0] a3,
   output logic        valid,
   output logic [1:0]  valid_ch,
   output logic        busy
);

   // state | meaning
   // IDLE  | CS high, waiting for ena
   // SETUP | CS low, SCK low for DIV clks before the first edge
   // SHIFT | 19 SCK periods of 2*DIV clks (low half, then high half)
   // HOLD  | CS low, SCK low for DIV clks; result written on exit
   // GAP   | CS high for 2*DIV clks; channel advances on exit
   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_SHIFT,
      S_HOLD,
      S_GAP
   } state_t;

   localparam logic [8:0] T_HALF   = 9'(DIV - 1);
   localparam logic [8:0] T_PER    = 9'(2 * DIV - 1);
   localparam logic [8:0] T_RISE   = 9'(DIV);
   localparam logic [4:0] LAST_PER = 5'd18;
   localparam logic [1:0] LAST_CH  = 2'(NCH - 1);

   state_t      state, state_nx;
   logic [8:0]  tmr;
   logic        tc;
   logic [4:0]  per;
   logic [1:0]  ch;
   logic [11:0] sr;
   logic [11:0] a_r [4];
   logic [11:0] result;

   assign tc = (tmr == 9'd0);

   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= S_IDLE;
         tmr      <= '0;
         per      <= '0;
         ch       <= '0;
         sr       <= '0;
         valid    <= 1'b0;
         valid_ch <= '0;
         for (int i = 0; i < 4; i++) a_r[i] <= '0;
      end else begin
         state <= state_nx;
         valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (ena) tmr <= T_HALF;
            end
            S_SETUP: begin
               if (tc) begin
                  tmr <= T_PER;
                  per <= '0;
               end else begin
                  tmr <= tmr - 9'd1;
               end
            end
            S_SHIFT: begin
               // tmr == DIV is the clk on which SCK rises; all 19 samples are
               // shifted in, so only periods 7..18 survive in the 12-bit register.
               if (tmr == T_RISE) sr <= {sr[10:0], adc_so};
               if (tc) begin
                  if (per == LAST_PER) begin
                     tmr <= T_HALF;
                  end else begin
                     per <= per + 5'd1;
                     tmr <= T_PER;
                  end
               end else begin
                  tmr <= tmr - 9'd1;
               end
            end
            S_HOLD: begin
               if (tc) begin
                  tmr      <= T_PER;
                  a_r[ch]  <= result;
                  valid    <= 1'b1;
                  valid_ch <= ch;
               end else begin
                  tmr <= tmr - 9'd1;
               end
            end
            S_GAP: begin
               if (tc) begin
                  tmr <= T_HALF;
                  ch  <= (ch == LAST_CH) ? 2'd0 : ch + 2'd1;
               end else begin
                  tmr <= tmr - 9'd1;
               end
            end
            default: tmr <= '0;
         endcase
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (ena) state_nx = S_SETUP;
         S_SETUP: if (tc) state_nx = S_SHIFT;
         S_SHIFT: if (tc && per == LAST_PER) state_nx = S_HOLD;
         S_HOLD:  if (tc) state_nx = S_GAP;
         S_GAP:   if (tc) state_nx = ena ? S_SETUP : S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      busy    = (state != S_IDLE);
      adc_cs  = (state == S_IDLE) || (state == S_GAP);
      adc_clk = (state == S_SHIFT) && (tmr < T_RISE);
      adc_si  = 1'b0;
      if (state == S_SHIFT) begin
         case (per)
            5'd0, 5'd1: adc_si = 1'b1;
            5'd3:       adc_si = ch[1];
            5'd4:       adc_si = ch[0];
            default:    adc_si = 1'b0;
         endcase
      end
   end

`ifdef ADC_FILT_EN
   logic signed [12:0] diff;
   logic signed [12:0] step;
   always_comb begin
      diff   = $signed({1'b0, sr}) - $signed({1'b0, a_r[ch]});
      step   = diff >>> 2;
      result = a_r[ch] + step[11:0];
   end
`else
   always_comb begin
      result = sr;
   end
`endif

   assign a0 = a_r[0];
   assign a1 = a_r[1];
   assign a2 = a_r[2];
   assign a3 = a_r[3];

endmodule

// File: tb/tb_adc_scan.sv
// -----------------------------------------------------------------------------
// tb_adc_scan
// Self-checking bench for adc_scan (DIV=2, NCH=4). A behavioural ADC decodes
// the command from MOSI, answers with a chosen 12-bit value behind seven
// random junk bits, and a scoreboard predicts every result register from the
// channel order and the values the ADC returned. Build with ADC_FILT_EN
// defined to check the filtered variant.
// -----------------------------------------------------------------------------
module tb_adc_scan;
   localparam int DIV = 2;
   localparam int NCH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        ena = 1'b0;
   logic        adc_so = 1'b0;
   logic        adc_cs, adc_si, adc_clk;
   logic [11:0] a0, a1, a2, a3;
   logic        valid;
   logic [1:0]  valid_ch;
   logic        busy;

   adc_scan #(.DIV(DIV), .NCH(NCH)) dut (
      .clk      (clk),
      .reset    (reset),
      .ena      (ena),
      .adc_cs   (adc_cs),
      .adc_si   (adc_si),
      .adc_clk  (adc_clk),
      .adc_so   (adc_so),
      .a0       (a0),
      .a1       (a1),
      .a2       (a2),
      .a3       (a3),
      .valid    (valid),
      .valid_ch (valid_ch),
      .busy     (busy)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected result after one update with a new sample.
   function automatic logic [11:0] next_val(input logic [11:0] old, input logic [11:0] s);
`ifdef ADC_FILT_EN
      int d;
      int q;
      d = int'(s) - int'(old);
      q = (d >= 0) ? d / 4 : -((-d + 3) / 4);
      return 12'(int'(old) + q);
`else
      return s;
`endif
   endfunction

   // ---------------- behavioural ADC ----------------
   int          n_rise = 0;
   logic [1:0]  cmd_ch = '0;
   logic [1:0]  cur_ch = '0;
   logic [11:0] cur_val = '0;
   int          mode = 0;
   int          exp_ch = 0;
   logic        exp_bit;
   bit          mon_en = 0;

   always @(negedge adc_cs) begin
      n_rise = 0;
      adc_so = 1'($urandom_range(0, 1));
   end

   always @(posedge adc_clk) begin
      if (mon_en) begin
         case (n_rise)
            0, 1:    exp_bit = 1'b1;
            3:       exp_bit = exp_ch[1];
            4:       exp_bit = exp_ch[0];
            default: exp_bit = 1'b0;
         endcase
         check("si_bit", adc_si, exp_bit);
      end
      if (n_rise == 3) cmd_ch[1] = adc_si;
      if (n_rise == 4) begin
         cmd_ch[0] = adc_si;
         cur_ch    = cmd_ch;
         cur_val   = (mode == 0) ? 12'(12'h111 * (int'(cur_ch) + 1)) : 12'($urandom);
      end
      n_rise++;
   end

   always @(negedge adc_clk) begin
      if (n_rise >= 7 && n_rise <= 18) adc_so = cur_val[18 - n_rise];
      else adc_so = 1'($urandom_range(0, 1));
   end

   // ---------------- frame monitor and scoreboard ----------------
   logic [11:0] a_exp [4];
   int   frames = 0;
   int   low_cnt = 0, hi_cnt = 0, rises = 0;
   bit   cs_q = 1, sck_q = 0, aborted = 0, gap_ok = 0, rose;

   always @(negedge clk) begin
      if (mon_en) begin
         rose = adc_cs && !cs_q;
         if (!adc_cs && cs_q) begin
            if (gap_ok) check("gap_len", 48'(hi_cnt), 48'(2 * DIV));
            gap_ok  = 1;
            low_cnt = 0;
            rises   = 0;
         end
         if (!adc_cs) begin
            low_cnt++;
            if (adc_clk && !sck_q) rises++;
         end
         if (valid || (rose && !aborted))
            check("valid_pulse", valid, rose && !aborted);
         if (rose && !aborted) begin
            check("frame_low", 48'(low_cnt), 48'(40 * DIV));
            check("sck_pulses", 48'(rises), 48'd19);
         end
         if (rose) begin
            hi_cnt  = 0;
            aborted = 0;
         end
         if (adc_cs) hi_cnt++;
         if (valid) begin
            check("valid_ch", valid_ch, cur_ch);
            a_exp[cur_ch] = next_val(a_exp[cur_ch], cur_val);
            check("results", {a0, a1, a2, a3}, {a_exp[0], a_exp[1], a_exp[2], a_exp[3]});
            exp_ch = (exp_ch + 1) % NCH;
            frames++;
         end
         if (!ena || !reset) gap_ok = 0;
         cs_q  = adc_cs;
         sck_q = adc_clk;
      end
   end

   task automatic wait_frames(input int k);
      int f0;
      int budget;
      f0     = frames;
      budget = k * 50 * DIV + 200;
      while (frames < f0 + k && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (frames < f0 + k) check("frame_timeout", 48'(frames), 48'(f0 + k));
   endtask

   task automatic wait_shift(input int ch_want, input int rise_want, input string tag);
      int budget;
      budget = 2000;
      while (!(exp_ch == ch_want && n_rise == rise_want && !adc_cs) && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      if (budget == 0) check(tag, 48'(n_rise), 48'(rise_want));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int f0;
      for (int i = 0; i < 4; i++) a_exp[i] = '0;

      reset = 1'b0;
      ena   = 1'b1;
      repeat (10) begin
         @(negedge clk);
         check("rst_cs", adc_cs, 1'b1);
         check("rst_sck", adc_clk, 1'b0);
         check("rst_si", adc_si, 1'b0);
         check("rst_a", {a0, a1, a2, a3}, 48'd0);
         check("rst_valid", valid, 1'b0);
         check("rst_busy", busy, 1'b0);
      end

      // round robin with the fixed 0x111*(ch+1) answers
      reset  = 1'b1;
      mon_en = 1;
      mode   = 0;
      wait_frames(5);
      check("rr_a", {a0, a1, a2, a3}, {12'h111, 12'h222, 12'h333, 12'h444});

      // random answers
      mode = 1;
      wait_frames(6);

      // drop ena in the middle of a ch1 frame
      wait_shift(1, 11, "wait_ch1");
      ena = 1'b0;
      f0  = frames;
      wait_frames(1);
      repeat (2 * DIV + 2) @(negedge clk);
      check("drop_busy", busy, 1'b0);
      check("drop_cs", adc_cs, 1'b1);
      repeat (20) @(negedge clk);
      check("drop_idle", busy, 1'b0);
      check("drop_frames", 48'(frames), 48'(f0 + 1));
      ena = 1'b1;
      wait_frames(1);
      check("resume_ch", cur_ch, 2'd2);
      wait_frames(2);

      // reset in the middle of a SHIFT
      wait_shift(exp_ch, 8, "wait_shift");
      reset   = 1'b0;
      aborted = 1;
      @(posedge clk);
      #1;
      check("mid_rst_cs", adc_cs, 1'b1);
      check("mid_rst_a", {a0, a1, a2, a3}, 48'd0);
      check("mid_rst_busy", busy, 1'b0);
      check("mid_rst_vch", valid_ch, 2'd0);
      for (int i = 0; i < 4; i++) a_exp[i] = '0;
      exp_ch = 0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      wait_frames(1);
      check("post_rst_ch", cur_ch, 2'd0);
      wait_frames(4);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
